jstk_frame_decoder: RTL and testbench

Consumes the 40-bit response frames returned by the SPI joystick transaction and turns them into validated, filtered X/Y positions, debounced buttons and a clamped Pong paddle position. It sits directly downstream of the SPI master. It accepts one frame per `frame_valid` pulse and drives the game logic and the hex display. Malformed frames are rejected and counted, and never reach the outputs.

---
 rtl/jstk_frame_decoder_if.sv | 22 ++
 rtl/jstk_frame_decoder.sv | 170 +++++++++++++++++
 tb/tb_jstk_frame_decoder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jstk_frame_decoder_if.sv
// Frame bus between the SPI master and the joystick frame decoder.
// The master drives the frame strobe and data; the decoder reports back busy and frame rejects.
interface jstk_frame_decoder_if;
  logic        frame_valid;
  logic [39:0] frame;
  logic        busy;
  logic        frame_err;

  modport master (
    output frame_valid,
    output frame,
    input  busy,
    input  frame_err
  );

  modport slave (
    input  frame_valid,
    input  frame,
    output busy,
    output frame_err
  );
endinterface

// File: rtl/jstk_frame_decoder.sv
// Validates 40-bit joystick frames, averages X/Y over 4 samples, debounces buttons
// and steps a clamped Pong paddle on each game tick.
module jstk_frame_decoder #(
  parameter int PADDLE_MAX  = 400,
  parameter int DEADZONE    = 64,
  parameter int SPEED_SHIFT = 6,
  parameter int DEBOUNCE    = 3
) (
  input  logic                 clk50M,
  input  logic                 rst_n,
  jstk_frame_decoder_if.slave  fbus,
  input  logic                 tick,
  output logic [9:0]           x_pos,
  output logic [9:0]           y_pos,
  output logic [2:0]           buttons,
  output logic [8:0]           paddle_pos,
  output logic [7:0]           err_count
);

  localparam logic [8:0]         PADDLE_RST   = 9'(PADDLE_MAX / 2);
  localparam logic [8:0]         PADDLE_TOP   = 9'(PADDLE_MAX);
  localparam logic signed [10:0] PADDLE_MAX_S = 11'(PADDLE_MAX);
  localparam logic [10:0]        DEADZONE_U   = 11'(DEADZONE);
  localparam logic [7:0]         DEBOUNCE_U   = 8'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PARSE, FILTER} state_t;

  state_t      state_reg, state_next;
  logic [39:0] cap_reg;
  logic        frame_err_reg;
  logic [7:0]  err_count_reg;
  logic        capture_en, err_en, filter_en;

  logic        frame_ok;
  logic [9:0]  x_raw, y_raw;
  logic [2:0]  btn_raw;

  assign frame_ok = (cap_reg[31:26] == 6'd0) && (cap_reg[15:10] == 6'd0);
  assign x_raw    = {cap_reg[25:24], cap_reg[39:32]};
  assign y_raw    = {cap_reg[9:8], cap_reg[23:16]};
  assign btn_raw  = cap_reg[2:0];

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fbus.frame_valid) state_next = PARSE;
      PARSE:   state_next = frame_ok ? FILTER : IDLE;
      FILTER:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_reg == IDLE) && fbus.frame_valid;
    err_en     = (state_reg == PARSE) && !frame_ok;
    filter_en  = (state_reg == FILTER);
  end

  assign fbus.busy      = (state_reg != IDLE);
  assign fbus.frame_err = frame_err_reg;
  assign err_count      = err_count_reg;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      cap_reg       <= '0;
      frame_err_reg <= 1'b0;
      err_count_reg <= 8'd0;
    end else begin
      if (capture_en) cap_reg <= fbus.frame;
      frame_err_reg <= err_en;
      if (err_en && err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
    end
  end

  // Shift chain: stage 0 takes the new sample, stage N takes stage N-1.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hist
    logic [9:0] x_reg, y_reg, x_in, y_in;
    if (gi == 0) begin : g_head
      assign x_in = x_raw;
      assign y_in = y_raw;
    end else begin : g_tail
      assign x_in = g_hist[gi-1].x_reg;
      assign y_in = g_hist[gi-1].y_reg;
    end
    always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
        x_reg <= 10'd512;
        y_reg <= 10'd512;
      end else if (filter_en) begin
        x_reg <= x_in;
        y_reg <= y_in;
      end
    end
  end

  logic [11:0] x_sum, y_sum;
  assign x_sum = {2'b00, g_hist[0].x_reg} + {2'b00, g_hist[1].x_reg}
               + {2'b00, g_hist[2].x_reg} + {2'b00, g_hist[3].x_reg};
  assign y_sum = {2'b00, g_hist[0].y_reg} + {2'b00, g_hist[1].y_reg}
               + {2'b00, g_hist[2].y_reg} + {2'b00, g_hist[3].y_reg};
  assign x_pos = x_sum[11:2];
  assign y_pos = y_sum[11:2];

  logic [2:0] buttons_reg, buttons_next, cand_reg, cand_next;
  logic [7:0] match_reg, match_next, match_inc;

  always_comb begin
    buttons_next = buttons_reg;
    cand_next    = cand_reg;
    match_next   = match_reg;
    match_inc    = 8'd1;
    if (filter_en) begin
      if (btn_raw == buttons_reg) begin
        match_next = 8'd0;
      end else begin
        match_inc = (btn_raw == cand_reg) ? match_reg + 8'd1 : 8'd1;
        cand_next = btn_raw;
        if (match_inc >= DEBOUNCE_U) begin
          buttons_next = btn_raw;
          match_next   = 8'd0;
        end else begin
          match_next   = match_inc;
        end
      end
    end
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      buttons_reg <= 3'd0;
      cand_reg    <= 3'd0;
      match_reg   <= 8'd0;
    end else begin
      buttons_reg <= buttons_next;
      cand_reg    <= cand_next;
      match_reg   <= match_next;
    end
  end
  assign buttons = buttons_reg;

  // Paddle reads the registered y_pos, so a tick alongside FILTER sees the old value.
  logic [8:0]         paddle_reg, paddle_next;
  logic signed [10:0] d, step, sum;
  logic [10:0]        abs_d;

  always_comb begin
    d           = $signed({1'b0, y_pos}) - 11'sd512;
    abs_d       = d[10] ? 11'(-d) : 11'(d);
    step        = d >>> SPEED_SHIFT;
    sum         = $signed({2'b00, paddle_reg}) + step;
    paddle_next = paddle_reg;
    if (tick && abs_d > DEADZONE_U) begin
      if (sum < 11'sd0)             paddle_next = 9'd0;
      else if (sum > PADDLE_MAX_S)  paddle_next = PADDLE_TOP;
      else                          paddle_next = sum[8:0];
    end
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) paddle_reg <= PADDLE_RST;
    else        paddle_reg <= paddle_next;
  end
  assign paddle_pos = paddle_reg;

endmodule

// File: tb/tb_jstk_frame_decoder.sv
// Directed bench for jstk_frame_decoder: filter, reject/drop, debounce, paddle, reset, saturation.
module tb_jstk_frame_decoder;
  logic       clk50M = 1'b0;
  logic       rst_n  = 1'b0;
  logic       tick   = 1'b0;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [8:0] paddle_pos;
  logic [7:0] err_count;
  int checks = 0;
  int failures = 0;

  jstk_frame_decoder_if fbus ();

  jstk_frame_decoder dut (
    .clk50M     (clk50M),
    .rst_n      (rst_n),
    .fbus       (fbus),
    .tick       (tick),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .paddle_pos (paddle_pos),
    .err_count  (err_count)
  );

  always #5 clk50M = ~clk50M;

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Pulses frame_valid for one cycle and returns at the negedge after E2.
  task automatic send_frame(input logic [39:0] f);
    @(negedge clk50M);
    fbus.frame_valid = 1'b1;
    fbus.frame       = f;
    @(negedge clk50M);
    fbus.frame_valid = 1'b0;
    @(negedge clk50M);
    @(negedge clk50M);
    $display("frame %h -> x=%0d y=%0d btn=%0d err=%0d", f, x_pos, y_pos, buttons, err_count);
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk50M);
      tick = 1'b1;
      @(negedge clk50M);
      tick = 1'b0;
    end
    $display("tick x%0d -> paddle=%0d (y=%0d)", n, paddle_pos, y_pos);
  endtask

  task automatic do_reset();
    @(negedge clk50M);
    rst_n = 1'b0;
    @(negedge clk50M);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (x_pos !== 10'd512 || y_pos !== 10'd512) begin
      failures++; $display("FAIL reset_xy: got x=%0d y=%0d, want 512/512", x_pos, y_pos);
    end
    checks++;
    if (buttons !== 3'd0 || paddle_pos !== 9'd200 || err_count !== 8'd0) begin
      failures++; $display("FAIL reset_misc: got btn=%0d pad=%0d err=%0d, want 0/200/0", buttons, paddle_pos, err_count);
    end
    checks++;
    if (fbus.busy !== 1'b0 || fbus.frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got busy=%b frame_err=%b, want 0/0", fbus.busy, fbus.frame_err);
    end
  endtask

  task automatic test_filter_ramp();
    logic [9:0] exp_y [4] = '{10'd639, 10'd767, 10'd895, 10'd1023};
    // First frame traced edge by edge to check busy timing.
    @(negedge clk50M);
    fbus.frame_valid = 1'b1;
    fbus.frame       = 40'h00_02_FF_03_01;
    @(negedge clk50M);
    fbus.frame_valid = 1'b0;
    checks++;
    if (fbus.busy !== 1'b1) begin failures++; $display("FAIL busy_e0: got %b, want 1", fbus.busy); end
    @(negedge clk50M);
    checks++;
    if (fbus.busy !== 1'b1) begin failures++; $display("FAIL busy_e1: got %b, want 1", fbus.busy); end
    checks++;
    if (y_pos !== 10'd512) begin failures++; $display("FAIL y_early: got %0d, want 512 before E2", y_pos); end
    @(negedge clk50M);
    checks++;
    if (fbus.busy !== 1'b0) begin failures++; $display("FAIL busy_e2: got %b, want 0", fbus.busy); end
    checks++;
    if (x_pos !== 10'd512 || y_pos !== exp_y[0]) begin
      failures++; $display("FAIL ramp_1: got x=%0d y=%0d, want 512/639", x_pos, y_pos);
    end
    for (int i = 1; i < 4; i++) begin
      send_frame(40'h00_02_FF_03_01);
      checks++;
      if (x_pos !== 10'd512 || y_pos !== exp_y[i]) begin
        failures++; $display("FAIL ramp_%0d: got x=%0d y=%0d, want 512/%0d", i + 1, x_pos, y_pos, exp_y[i]);
      end
    end
    checks++;
    if (buttons !== 3'd1) begin failures++; $display("FAIL ramp_btn: got %0d, want 1", buttons); end
  endtask

  task automatic test_reject_drop();
    @(negedge clk50M);
    fbus.frame_valid = 1'b1;
    fbus.frame       = 40'h00_04_00_02_00;
    @(negedge clk50M);
    checks++;
    if (fbus.frame_err !== 1'b0) begin failures++; $display("FAIL err_early: got %b, want 0", fbus.frame_err); end
    // Valid frame strobed while busy: must be dropped.
    fbus.frame = 40'h00_00_00_00_00;
    @(negedge clk50M);
    fbus.frame_valid = 1'b0;
    checks++;
    if (fbus.frame_err !== 1'b1 || err_count !== 8'd1) begin
      failures++; $display("FAIL err_pulse: got frame_err=%b count=%0d, want 1/1", fbus.frame_err, err_count);
    end
    @(negedge clk50M);
    checks++;
    if (fbus.frame_err !== 1'b0) begin failures++; $display("FAIL err_width: got %b, want 0", fbus.frame_err); end
    repeat (4) @(negedge clk50M);
    $display("reject -> x=%0d y=%0d btn=%0d err=%0d", x_pos, y_pos, buttons, err_count);
    checks++;
    if (x_pos !== 10'd512 || y_pos !== 10'd1023 || buttons !== 3'd1 || err_count !== 8'd1) begin
      failures++; $display("FAIL reject_hold: got x=%0d y=%0d btn=%0d err=%0d, want 512/1023/1/1", x_pos, y_pos, buttons, err_count);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    send_frame(40'h00_02_00_02_01);
    send_frame(40'h00_02_00_02_01);
    send_frame(40'h00_02_00_02_00);
    checks++;
    if (buttons !== 3'd0) begin failures++; $display("FAIL deb_glitch: got %0d, want 0", buttons); end
    send_frame(40'h00_02_00_02_01);
    send_frame(40'h00_02_00_02_01);
    checks++;
    if (buttons !== 3'd0) begin failures++; $display("FAIL deb_two: got %0d, want 0", buttons); end
    send_frame(40'h00_02_00_02_01);
    checks++;
    if (buttons !== 3'd1) begin failures++; $display("FAIL deb_three: got %0d, want 1", buttons); end
  endtask

  task automatic test_paddle();
    repeat (4) send_frame(40'h00_02_FF_03_01);
    do_tick(1);
    checks++;
    if (paddle_pos !== 9'd207) begin failures++; $display("FAIL pad_step: got %0d, want 207", paddle_pos); end
    do_tick(27);
    checks++;
    if (paddle_pos !== 9'd396) begin failures++; $display("FAIL pad_28: got %0d, want 396", paddle_pos); end
    do_tick(1);
    checks++;
    if (paddle_pos !== 9'd400) begin failures++; $display("FAIL pad_clamp_hi: got %0d, want 400", paddle_pos); end
    do_tick(3);
    checks++;
    if (paddle_pos !== 9'd400) begin failures++; $display("FAIL pad_hold_hi: got %0d, want 400", paddle_pos); end
    repeat (4) send_frame(40'h00_02_3A_02_01);
    do_tick(3);
    checks++;
    if (y_pos !== 10'd570 || paddle_pos !== 9'd400) begin
      failures++; $display("FAIL dz_570: got y=%0d pad=%0d, want 570/400", y_pos, paddle_pos);
    end
    repeat (4) send_frame(40'h00_01_C0_01_01);
    do_tick(3);
    checks++;
    if (y_pos !== 10'd448 || paddle_pos !== 9'd400) begin
      failures++; $display("FAIL dz_edge: got y=%0d pad=%0d, want 448/400", y_pos, paddle_pos);
    end
    repeat (4) send_frame(40'h00_01_BF_01_01);
    do_tick(1);
    checks++;
    if (y_pos !== 10'd447 || paddle_pos !== 9'd398) begin
      failures++; $display("FAIL dz_out: got y=%0d pad=%0d, want 447/398", y_pos, paddle_pos);
    end
    repeat (4) send_frame(40'h00_00_00_00_01);
    do_tick(49);
    checks++;
    if (y_pos !== 10'd0 || paddle_pos !== 9'd6) begin
      failures++; $display("FAIL pad_down: got y=%0d pad=%0d, want 0/6", y_pos, paddle_pos);
    end
    do_tick(3);
    checks++;
    if (paddle_pos !== 9'd0) begin failures++; $display("FAIL pad_clamp_lo: got %0d, want 0", paddle_pos); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(40'h00_04_00_00_00);
    @(negedge clk50M);
    fbus.frame_valid = 1'b1;
    fbus.frame       = 40'h00_02_FF_03_07;
    @(negedge clk50M);
    fbus.frame_valid = 1'b0;
    @(negedge clk50M);
    rst_n = 1'b0;
    @(negedge clk50M);
    checks++;
    if (x_pos !== 10'd512 || y_pos !== 10'd512 || buttons !== 3'd0 || paddle_pos !== 9'd200 || err_count !== 8'd0 || fbus.busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got x=%0d y=%0d btn=%0d pad=%0d err=%0d busy=%b, want 512/512/0/200/0/0",
                           x_pos, y_pos, buttons, paddle_pos, err_count, fbus.busy);
    end
    rst_n = 1'b1;
    @(negedge clk50M);
    checks++;
    if (y_pos !== 10'd512 || buttons !== 3'd0) begin
      failures++; $display("FAIL mid_release: got y=%0d btn=%0d, want 512/0", y_pos, buttons);
    end
    send_frame(40'h00_02_FF_03_01);
    checks++;
    if (y_pos !== 10'd639) begin failures++; $display("FAIL hist_reset: got %0d, want 639", y_pos); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 254; i++) send_frame(40'h00_00_00_FC_00);
    checks++;
    if (err_count !== 8'd254) begin failures++; $display("FAIL sat_254: got %0d, want 254", err_count); end
    for (int i = 0; i < 46; i++) send_frame(40'h00_00_00_FC_00);
    checks++;
    if (err_count !== 8'd255) begin failures++; $display("FAIL sat_300: got %0d, want 255", err_count); end
    checks++;
    if (y_pos !== 10'd639) begin failures++; $display("FAIL sat_y_hold: got %0d, want 639", y_pos); end
  endtask

  initial begin
    fbus.frame_valid = 1'b0;
    fbus.frame       = '0;
    repeat (2) @(negedge clk50M);
    test_reset();
    test_filter_ramp();
    test_reject_drop();
    test_debounce();
    test_paddle();
    test_reset_mid_frame();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
